// File: rtl/yags_predictor_core_pkg.sv
// Shared configuration, types and counter helpers for the YAGS direction predictor.
package yags_pkg;

   localparam int PC_W        = 10;
   localparam int GHR_W       = 10;
   localparam int CACHE_IDX_W = 8;
   localparam int TAG_W       = 6;
   localparam int CTR_W       = 2;
   localparam int SWEEP_W     = (PC_W > CACHE_IDX_W) ? PC_W : CACHE_IDX_W;

   localparam logic [CTR_W-1:0] WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] WT  = CTR_W'(1 << (CTR_W - 1));

   typedef struct packed {
      logic [GHR_W-1:0] ghr;
      logic             choice;
      logic             hit;
   } meta_t;

   typedef logic [0:0] state_e;
   localparam state_e INIT = 1'b0;
   localparam state_e RUN  = 1'b1;

   function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
      return (c == {CTR_W{1'b1}}) ? c : c + CTR_W'(1);
   endfunction

   function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
      return (c == '0) ? c : c - CTR_W'(1);
   endfunction

endpackage

// File: rtl/yags_predictor_core_if.sv
// Fetch/EX facing bundle of the predictor: request, prediction and resolved-update channels.
interface yags_predictor_core_if;
   import yags_pkg::*;

   logic            req_valid;
   logic [PC_W-1:0] req_pc;
   logic            busy;
   logic            pred_valid;
   logic            pred_taken;
   meta_t           pred_meta;
   logic            upd_valid;
   logic [PC_W-1:0] upd_pc;
   logic            upd_taken;
   logic            upd_pred;
   meta_t           upd_meta;

   modport master (
      output req_valid, req_pc, upd_valid, upd_pc, upd_taken, upd_pred, upd_meta,
      input  busy, pred_valid, pred_taken, pred_meta
   );

   modport slave (
      input  req_valid, req_pc, upd_valid, upd_pc, upd_taken, upd_pred, upd_meta,
      output busy, pred_valid, pred_taken, pred_meta
   );

endinterface

// File: rtl/yags_predictor_core_exc_cache.sv
// Tagged exception cache: async read for prediction, one read-modify-write port for EX updates.
module yags_exc_cache
   import yags_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   clr_i,
   input  logic [CACHE_IDX_W-1:0] clr_idx_i,
   input  logic [CACHE_IDX_W-1:0] rd_idx_i,
   output logic                   rd_valid_o,
   output logic [TAG_W-1:0]       rd_tag_o,
   output logic                   rd_ctr_msb_o,
   input  logic                   wr_en_i,
   input  logic [CACHE_IDX_W-1:0] wr_idx_i,
   input  logic [TAG_W-1:0]       wr_tag_i,
   input  logic                   wr_alloc_i,
   input  logic                   wr_taken_i
);

   localparam int DEPTH = 1 << CACHE_IDX_W;

   logic             valid_q [DEPTH];
   logic [TAG_W-1:0] tag_q   [DEPTH];
   logic [CTR_W-1:0] ctr_q   [DEPTH];

   assign rd_valid_o   = valid_q[rd_idx_i];
   assign rd_tag_o     = tag_q[rd_idx_i];
   assign rd_ctr_msb_o = ctr_q[rd_idx_i][CTR_W-1];

   // The init sweep owns the arrays; a fresh allocation seeds a weak counter, a hit trains it.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         valid_q[clr_idx_i] <= 1'b0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= 1'b1;
         tag_q[wr_idx_i]   <= wr_tag_i;
         if (wr_alloc_i)
            ctr_q[wr_idx_i] <= wr_taken_i ? WT : WNT;
         else
            ctr_q[wr_idx_i] <= wr_taken_i ? ctr_inc(ctr_q[wr_idx_i]) : ctr_dec(ctr_q[wr_idx_i]);
      end
   end

endmodule

// File: rtl/yags_predictor_core.sv
// YAGS direction predictor: choice PHT plus T/NT exception caches, speculative GHR with repair.
module yags_predictor_core
   import yags_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   yags_predictor_core_if.slave  bus_if
);

   state_e             state_q;
   logic [SWEEP_W-1:0] idx_q;
   logic [GHR_W-1:0]   ghr_q, ghr_d;
   logic               predValid_q, predTaken_q;
   meta_t              predMeta_q;

   logic [CTR_W-1:0]   pht_q [1 << PC_W];

   logic                   accept, updEn, phtInitEn, cacheClr;
   logic                   reqChoice, reqHit, reqTaken;
   logic [CACHE_IDX_W-1:0] reqIdx, updIdx;
   logic [TAG_W-1:0]       reqTag, updTag;
   logic                   tValid, ntValid, tCtrMsb, ntCtrMsb;
   logic [TAG_W-1:0]       tTag, ntTag;
   logic                   selValid, selCtrMsb;
   logic [TAG_W-1:0]       selTag;
   logic [CTR_W-1:0]       updPhtOld;
   logic                   phtUpdEn, cacheWrEn, cacheAlloc;

   assign accept    = (state_q == RUN) && bus_if.req_valid;
   assign updEn     = (state_q == RUN) && bus_if.upd_valid && !rst_i;
   assign phtInitEn = (state_q == INIT) && (int'(idx_q) < (1 << PC_W));
   assign cacheClr  = (state_q == INIT) && (int'(idx_q) < (1 << CACHE_IDX_W));

   assign reqChoice = pht_q[bus_if.req_pc][CTR_W-1];
   assign reqIdx    = bus_if.req_pc[CACHE_IDX_W-1:0] ^ ghr_q[CACHE_IDX_W-1:0];
   assign reqTag    = bus_if.req_pc[PC_W-1 -: TAG_W];
   assign selValid  = reqChoice ? ntValid  : tValid;
   assign selTag    = reqChoice ? ntTag    : tTag;
   assign selCtrMsb = reqChoice ? ntCtrMsb : tCtrMsb;
   assign reqHit    = selValid && (selTag == reqTag);
   assign reqTaken  = reqHit ? selCtrMsb : reqChoice;

   assign updIdx     = bus_if.upd_pc[CACHE_IDX_W-1:0] ^ bus_if.upd_meta.ghr[CACHE_IDX_W-1:0];
   assign updTag     = bus_if.upd_pc[PC_W-1 -: TAG_W];
   assign updPhtOld  = pht_q[bus_if.upd_pc];
   // A correct exception entry that overrode the choice must not erode the choice counter.
   assign phtUpdEn   = !(bus_if.upd_meta.hit && (bus_if.upd_pred == bus_if.upd_taken)
                         && (bus_if.upd_meta.choice != bus_if.upd_taken));
   assign cacheAlloc = !bus_if.upd_meta.hit;
   assign cacheWrEn  = updEn && (bus_if.upd_meta.hit || (bus_if.upd_meta.choice != bus_if.upd_taken));

   // Mispredict repair wins over the speculative shift of a same-cycle request.
   always_comb begin
      ghr_d = ghr_q;
      if (updEn && (bus_if.upd_pred != bus_if.upd_taken))
         ghr_d = {bus_if.upd_meta.ghr[GHR_W-2:0], bus_if.upd_taken};
      else if (accept)
         ghr_d = {ghr_q[GHR_W-2:0], reqTaken};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= INIT;
         idx_q       <= '0;
         ghr_q       <= '0;
         predValid_q <= 1'b0;
         predTaken_q <= 1'b0;
         predMeta_q  <= '0;
      end else begin
         ghr_q       <= ghr_d;
         predValid_q <= accept;
         if (accept) begin
            predTaken_q <= reqTaken;
            predMeta_q  <= '{ghr: ghr_q, choice: reqChoice, hit: reqHit};
         end
         if (state_q == INIT) begin
            idx_q <= idx_q + SWEEP_W'(1);
            if (idx_q == {SWEEP_W{1'b1}})
               state_q <= RUN;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (phtInitEn)
         pht_q[idx_q[PC_W-1:0]] <= WNT;
      else if (updEn && phtUpdEn)
         pht_q[bus_if.upd_pc] <= bus_if.upd_taken ? ctr_inc(updPhtOld) : ctr_dec(updPhtOld);
   end

   yags_exc_cache u_tCache (
      .clk_i        (clk_i),
      .clr_i        (cacheClr),
      .clr_idx_i    (idx_q[CACHE_IDX_W-1:0]),
      .rd_idx_i     (reqIdx),
      .rd_valid_o   (tValid),
      .rd_tag_o     (tTag),
      .rd_ctr_msb_o (tCtrMsb),
      .wr_en_i      (cacheWrEn && !bus_if.upd_meta.choice),
      .wr_idx_i     (updIdx),
      .wr_tag_i     (updTag),
      .wr_alloc_i   (cacheAlloc),
      .wr_taken_i   (bus_if.upd_taken)
   );

   yags_exc_cache u_ntCache (
      .clk_i        (clk_i),
      .clr_i        (cacheClr),
      .clr_idx_i    (idx_q[CACHE_IDX_W-1:0]),
      .rd_idx_i     (reqIdx),
      .rd_valid_o   (ntValid),
      .rd_tag_o     (ntTag),
      .rd_ctr_msb_o (ntCtrMsb),
      .wr_en_i      (cacheWrEn && bus_if.upd_meta.choice),
      .wr_idx_i     (updIdx),
      .wr_tag_i     (updTag),
      .wr_alloc_i   (cacheAlloc),
      .wr_taken_i   (bus_if.upd_taken)
   );

   assign bus_if.busy       = (state_q == INIT);
   assign bus_if.pred_valid = predValid_q;
   assign bus_if.pred_taken = predTaken_q;
   assign bus_if.pred_meta  = predMeta_q;

endmodule

// File: tb/tb_yags_predictor_core.sv
// Directed bench for yags_predictor_core: init sweep, allocation, cache hits, GHR repair, saturation.
module tb_yags_predictor_core;
   import yags_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   assertCount = 0;
   int   failCount   = 0;

   always #5 clk = ~clk;

   yags_predictor_core_if busIf ();

   yags_predictor_core dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_if (busIf)
   );

   // Runaway guard in case the DUT never leaves a wait.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic meta_t mkMeta(input logic [GHR_W-1:0] g, input logic c, input logic h);
      meta_t m;
      m.ghr    = g;
      m.choice = c;
      m.hit    = h;
      return m;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle of request/update traffic, then returns the valids to idle.
   task automatic applyStimulus(input logic reqV, input logic [PC_W-1:0] reqPc,
                                input logic updV, input logic [PC_W-1:0] updPc,
                                input logic updTaken, input logic updPred, input meta_t updMeta);
      busIf.req_valid = reqV;
      busIf.req_pc    = reqPc;
      busIf.upd_valid = updV;
      busIf.upd_pc    = updPc;
      busIf.upd_taken = updTaken;
      busIf.upd_pred  = updPred;
      busIf.upd_meta  = updMeta;
      tick();
      busIf.req_valid = 1'b0;
      busIf.upd_valid = 1'b0;
   endtask

   task automatic predict(input logic [PC_W-1:0] pc);
      applyStimulus(1'b1, pc, 1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic update(input logic [PC_W-1:0] pc, input logic taken, input logic pred, input meta_t m);
      applyStimulus(1'b0, '0, 1'b1, pc, taken, pred, m);
   endtask

   task automatic countBusy(output int n);
      n = 0;
      while (busIf.busy === 1'b1 && n < 3000) begin
         n++;
         tick();
      end
   endtask

   int  busyLen;
   logic leak;

   initial begin
      busIf.req_valid = 1'b0;
      busIf.req_pc    = '0;
      busIf.upd_valid = 1'b0;
      busIf.upd_pc    = '0;
      busIf.upd_taken = 1'b0;
      busIf.upd_pred  = 1'b0;
      busIf.upd_meta  = '0;

      $display("[TB] reset and init sweep");
      rst = 1'b1;
      repeat (3) tick();
      checkOutput("rst_pred_valid", 32'(busIf.pred_valid), 32'd0);
      checkOutput("rst_pred_taken", 32'(busIf.pred_taken), 32'd0);
      checkOutput("rst_pred_meta",  32'(busIf.pred_meta),  32'd0);
      checkOutput("rst_busy",       32'(busIf.busy),       32'd1);
      rst = 1'b0;
      countBusy(busyLen);
      checkOutput("sweep_len", 32'(busyLen), 32'd1024);
      checkOutput("busy_low", 32'(busIf.busy), 32'd0);

      $display("[TB] first prediction");
      predict(10'h005);
      checkOutput("t1_valid", 32'(busIf.pred_valid), 32'd1);
      checkOutput("t1_taken", 32'(busIf.pred_taken), 32'd0);
      checkOutput("t1_hit",   32'(busIf.pred_meta.hit), 32'd0);
      checkOutput("t1_ghr",   32'(busIf.pred_meta.ghr), 32'h000);

      $display("[TB] choice PHT training");
      update(10'h040, 1'b1, 1'b1, mkMeta(10'h000, 1'b0, 1'b0));
      update(10'h040, 1'b1, 1'b1, mkMeta(10'h000, 1'b0, 1'b0));
      predict(10'h040);
      checkOutput("t2_taken",  32'(busIf.pred_taken), 32'd1);
      checkOutput("t2_choice", 32'(busIf.pred_meta.choice), 32'd1);
      checkOutput("t2_hit",    32'(busIf.pred_meta.hit), 32'd0);
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput("idle_valid", 32'(busIf.pred_valid), 32'd0);
      checkOutput("idle_hold",  32'(busIf.pred_taken), 32'd1);

      $display("[TB] NT cache allocation and hit");
      update(10'h040, 1'b0, 1'b1, mkMeta(10'h000, 1'b1, 1'b0));
      predict(10'h040);
      checkOutput("t3_hit",   32'(busIf.pred_meta.hit), 32'd1);
      checkOutput("t3_taken", 32'(busIf.pred_taken), 32'd0);
      checkOutput("t3_ghr",   32'(busIf.pred_meta.ghr), 32'h000);
      update(10'h040, 1'b0, 1'b0, mkMeta(10'h000, 1'b1, 1'b1));
      predict(10'h040);
      checkOutput("t3b_choice", 32'(busIf.pred_meta.choice), 32'd1);
      checkOutput("t3b_hit",    32'(busIf.pred_meta.hit), 32'd1);
      checkOutput("t3b_taken",  32'(busIf.pred_taken), 32'd0);

      $display("[TB] speculative GHR and repair");
      update(10'h080, 1'b1, 1'b1, mkMeta(10'h000, 1'b0, 1'b0));
      update(10'h080, 1'b1, 1'b1, mkMeta(10'h000, 1'b0, 1'b0));
      predict(10'h080);
      checkOutput("t4_p0_taken", 32'(busIf.pred_taken), 32'd1);
      checkOutput("t4_p0_ghr",   32'(busIf.pred_meta.ghr), 32'h000);
      predict(10'h080);
      checkOutput("t4_p1_ghr",   32'(busIf.pred_meta.ghr), 32'h001);
      predict(10'h080);
      checkOutput("t4_p2_ghr",   32'(busIf.pred_meta.ghr), 32'h003);
      applyStimulus(1'b1, 10'h080, 1'b1, 10'h3FF, 1'b1, 1'b0, mkMeta(10'h155, 1'b0, 1'b0));
      checkOutput("t4_same_valid", 32'(busIf.pred_valid), 32'd1);
      checkOutput("t4_same_ghr",   32'(busIf.pred_meta.ghr), 32'h007);
      predict(10'h080);
      checkOutput("t4_repair_ghr", 32'(busIf.pred_meta.ghr), 32'h2AB);
      checkOutput("t4_repair_taken", 32'(busIf.pred_taken), 32'd1);

      $display("[TB] counter saturation");
      repeat (5) update(10'h0FF, 1'b1, 1'b1, mkMeta(10'h000, 1'b0, 1'b0));
      predict(10'h0FF);
      checkOutput("t5_up5", 32'(busIf.pred_meta.choice), 32'd1);
      update(10'h0FF, 1'b0, 1'b0, mkMeta(10'h000, 1'b0, 1'b0));
      predict(10'h0FF);
      checkOutput("t5_dn1", 32'(busIf.pred_meta.choice), 32'd1);
      update(10'h0FF, 1'b0, 1'b0, mkMeta(10'h000, 1'b0, 1'b0));
      predict(10'h0FF);
      checkOutput("t5_dn2", 32'(busIf.pred_meta.choice), 32'd0);
      repeat (3) update(10'h0FF, 1'b0, 1'b0, mkMeta(10'h000, 1'b0, 1'b0));
      predict(10'h0FF);
      checkOutput("t5_dn5", 32'(busIf.pred_meta.choice), 32'd0);
      update(10'h0FF, 1'b1, 1'b1, mkMeta(10'h000, 1'b0, 1'b0));
      predict(10'h0FF);
      checkOutput("t5_up_a", 32'(busIf.pred_meta.choice), 32'd0);
      update(10'h0FF, 1'b1, 1'b1, mkMeta(10'h000, 1'b0, 1'b0));
      predict(10'h0FF);
      checkOutput("t5_up_b", 32'(busIf.pred_meta.choice), 32'd1);

      $display("[TB] reset during sweep");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (300) tick();
      checkOutput("t6_busy_at300", 32'(busIf.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      busIf.req_valid = 1'b1;
      busIf.req_pc    = 10'h0FF;
      busIf.upd_valid = 1'b1;
      busIf.upd_pc    = 10'h0FF;
      busIf.upd_taken = 1'b1;
      busIf.upd_pred  = 1'b0;
      busIf.upd_meta  = mkMeta(10'h3FF, 1'b0, 1'b0);
      leak    = 1'b0;
      busyLen = 0;
      while (busIf.busy === 1'b1 && busyLen < 3000) begin
         if (busIf.pred_valid !== 1'b0) leak = 1'b1;
         busyLen++;
         tick();
      end
      busIf.req_valid = 1'b0;
      busIf.upd_valid = 1'b0;
      checkOutput("t6_sweep_len", 32'(busyLen), 32'd1024);
      checkOutput("t6_no_accept", 32'(leak), 32'd0);
      predict(10'h0FF);
      checkOutput("t6_choice", 32'(busIf.pred_meta.choice), 32'd0);
      checkOutput("t6_ghr",    32'(busIf.pred_meta.ghr), 32'h000);
      checkOutput("t6_taken",  32'(busIf.pred_taken), 32'd0);
      predict(10'h040);
      checkOutput("t6_cache_clr", 32'(busIf.pred_meta.hit), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
